// File: rtl/wb_dma_copier.sv
// Word-copy DMA: Wishbone responder for SRC/DST/LEN/CTRL plus a Wishbone initiator doing read/write beat pairs.
// Optional master timeout is enabled by defining WB_DMA_TIMEOUT_EN.
// state   | meaning
// S_IDLE  | no transfer, BUSY reads 0
// S_READ  | single-word read from SRC, data lands in buffer
// S_WRITE | single-word write of buffer to DST, then end-of-word update
module wb_dma_copier #(
    parameter int LEN_W   = 16,
    parameter int TIMEOUT = 255
) (
    input  logic        wb_clk_i,
    input  logic        wb_rst_n_i,
    input  logic        s_cyc_i,
    input  logic        s_stb_i,
    input  logic        s_we_i,
    input  logic [1:0]  s_adr_i,
    input  logic [31:0] s_dat_i,
    input  logic [3:0]  s_sel_i,
    output logic [31:0] s_dat_o,
    output logic        s_ack_o,
    output logic        m_cyc_o,
    output logic        m_stb_o,
    output logic        m_we_o,
    output logic [31:0] m_adr_o,
    output logic [3:0]  m_sel_o,
    output logic [31:0] m_dat_o,
    input  logic [31:0] m_dat_i,
    input  logic        m_ack_i,
    input  logic        m_err_i,
    output logic        irq_o
);

    typedef enum logic [1:0] {S_IDLE = 2'd0, S_READ = 2'd1, S_WRITE = 2'd2} state_t;

    state_t           state, state_nxt;
    logic [31:0]      src, dst, buffer, rdata;
    logic [LEN_W-1:0] len, len_dec;
    logic             done, ie, err, tmo, abort_pend, zero_start;
    logic             s_req, reg_wr, ctrl_wr, busy, start;
    logic             bus_ack, bus_err, tmo_hit, word_done, finish;
    logic             stb_nxt, we_nxt;
    logic [31:0]      adr_nxt, dat_nxt;
    logic             unused_ok;

    assign unused_ok = (^s_sel_i) ^ (TIMEOUT == 0);

    // The ~s_ack_o term keeps ack from ever being high on two consecutive cycles.
    assign s_req     = s_cyc_i & s_stb_i & ~s_ack_o;
    assign reg_wr    = s_req & s_we_i;
    assign ctrl_wr   = reg_wr & (s_adr_i == 2'd3);
    assign busy      = (state != S_IDLE);
    assign start     = ctrl_wr & s_dat_i[0] & ~busy;

    assign bus_err   = m_stb_o & (m_err_i | tmo_hit);
    assign bus_ack   = m_stb_o & m_ack_i & ~m_err_i;
    assign word_done = (state == S_WRITE) & bus_ack;
    assign len_dec   = len - LEN_W'(1);
    assign finish    = word_done & ((len_dec == '0) | abort_pend);

    assign m_sel_o   = 4'b1111;
    assign irq_o     = done & ie;

`ifdef WB_DMA_TIMEOUT_EN
    localparam int TW = $clog2(TIMEOUT + 1);
    logic [TW-1:0] tmo_cnt;

    // Counter restarts whenever strobe is low, i.e. between beats.
    always_ff @(posedge wb_clk_i or negedge wb_rst_n_i) begin
        if (!wb_rst_n_i) begin
            tmo_cnt <= '0;
            tmo     <= 1'b0;
        end else begin
            if (!m_stb_o)
                tmo_cnt <= '0;
            else if (tmo_cnt != TW'(TIMEOUT - 1))
                tmo_cnt <= tmo_cnt + TW'(1);
            if (ctrl_wr && s_dat_i[5])
                tmo <= 1'b0;
            if (start)
                tmo <= 1'b0;
            if (tmo_hit)
                tmo <= 1'b1;
        end
    end

    assign tmo_hit = m_stb_o & ~m_ack_i & ~m_err_i & (tmo_cnt == TW'(TIMEOUT - 1));
`else
    assign tmo     = 1'b0;
    assign tmo_hit = 1'b0;
`endif

    always_comb begin
        rdata = '0;
        case (s_adr_i)
            2'd0: rdata = src;
            2'd1: rdata = dst;
            2'd2: rdata = 32'(len);
            default: rdata = {26'd0, tmo, 1'b0, err, ie, done, busy};
        endcase
    end

    always_ff @(posedge wb_clk_i or negedge wb_rst_n_i) begin
        if (!wb_rst_n_i) begin
            s_ack_o    <= 1'b0;
            s_dat_o    <= '0;
            src        <= '0;
            dst        <= '0;
            len        <= '0;
            buffer     <= '0;
            done       <= 1'b0;
            ie         <= 1'b0;
            err        <= 1'b0;
            abort_pend <= 1'b0;
            zero_start <= 1'b0;
        end else begin
            s_ack_o    <= s_req;
            if (s_req)
                s_dat_o <= rdata;
            zero_start <= start & (len == '0);
            if (reg_wr && !busy) begin
                case (s_adr_i)
                    2'd0: src <= {s_dat_i[31:2], 2'b00};
                    2'd1: dst <= {s_dat_i[31:2], 2'b00};
                    2'd2: len <= s_dat_i[LEN_W-1:0];
                    default: ;
                endcase
            end
            if (word_done) begin
                src <= src + 32'd4;
                dst <= dst + 32'd4;
                len <= len_dec;
            end
            if ((state == S_READ) && bus_ack)
                buffer <= m_dat_i;
            if (ctrl_wr)
                ie <= s_dat_i[2];
            // Clears come first so that a same-cycle completion wins over W1C.
            if (ctrl_wr && s_dat_i[1])
                done <= 1'b0;
            if (ctrl_wr && s_dat_i[3])
                err <= 1'b0;
            if (start) begin
                done <= 1'b0;
                err  <= 1'b0;
            end
            if (finish || bus_err || zero_start)
                done <= 1'b1;
            if (bus_err)
                err <= 1'b1;
            if (busy && (state_nxt == S_IDLE))
                abort_pend <= 1'b0;
            else if (ctrl_wr && s_dat_i[4] && busy)
                abort_pend <= 1'b1;
        end
    end

    always_ff @(posedge wb_clk_i or negedge wb_rst_n_i) begin
        if (!wb_rst_n_i)
            state <= S_IDLE;
        else
            state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            S_IDLE:
                if (start && (len != '0))
                    state_nxt = S_READ;
            S_READ:
                if (bus_err)
                    state_nxt = S_IDLE;
                else if (bus_ack)
                    state_nxt = S_WRITE;
            S_WRITE:
                if (bus_err || finish)
                    state_nxt = S_IDLE;
                else if (bus_ack)
                    state_nxt = S_READ;
            default:
                state_nxt = S_IDLE;
        endcase
    end

    // A beat is issued only from a cycle with strobe low, which forces the idle gap between beats.
    always_comb begin
        stb_nxt = 1'b0;
        we_nxt  = 1'b0;
        adr_nxt = m_adr_o;
        dat_nxt = m_dat_o;
        if (m_stb_o) begin
            if (!bus_ack && !bus_err) begin
                stb_nxt = 1'b1;
                we_nxt  = m_we_o;
            end
        end else if (state == S_READ) begin
            stb_nxt = 1'b1;
            adr_nxt = src;
        end else if (state == S_WRITE) begin
            stb_nxt = 1'b1;
            we_nxt  = 1'b1;
            adr_nxt = dst;
            dat_nxt = buffer;
        end
    end

    always_ff @(posedge wb_clk_i or negedge wb_rst_n_i) begin
        if (!wb_rst_n_i) begin
            m_cyc_o <= 1'b0;
            m_stb_o <= 1'b0;
            m_we_o  <= 1'b0;
            m_adr_o <= '0;
            m_dat_o <= '0;
        end else begin
            m_cyc_o <= stb_nxt;
            m_stb_o <= stb_nxt;
            m_we_o  <= we_nxt;
            m_adr_o <= adr_nxt;
            m_dat_o <= dat_nxt;
        end
    end

endmodule

// File: tb/tb_wb_dma_copier.sv
// Self-checking bench for wb_dma_copier: zero-wait memory model with a bus-transaction scoreboard.
// Define WB_DMA_TIMEOUT_EN to also exercise the master timeout.
module tb_wb_dma_copier;

    logic        wb_clk_i = 1'b0;
    logic        wb_rst_n_i = 1'b0;
    logic        s_cyc_i = 1'b0, s_stb_i = 1'b0, s_we_i = 1'b0;
    logic [1:0]  s_adr_i = '0;
    logic [31:0] s_dat_i = '0;
    logic [3:0]  s_sel_i = 4'hF;
    logic [31:0] s_dat_o;
    logic        s_ack_o;
    logic        m_cyc_o, m_stb_o, m_we_o;
    logic [31:0] m_adr_o, m_dat_o;
    logic [3:0]  m_sel_o;
    logic [31:0] m_dat_i = '0;
    logic        m_ack_i = 1'b0, m_err_i = 1'b0;
    logic        irq_o;

    wb_dma_copier #(.LEN_W(16), .TIMEOUT(8)) dut (
        .wb_clk_i(wb_clk_i), .wb_rst_n_i(wb_rst_n_i),
        .s_cyc_i(s_cyc_i), .s_stb_i(s_stb_i), .s_we_i(s_we_i), .s_adr_i(s_adr_i),
        .s_dat_i(s_dat_i), .s_sel_i(s_sel_i), .s_dat_o(s_dat_o), .s_ack_o(s_ack_o),
        .m_cyc_o(m_cyc_o), .m_stb_o(m_stb_o), .m_we_o(m_we_o), .m_adr_o(m_adr_o),
        .m_sel_o(m_sel_o), .m_dat_o(m_dat_o), .m_dat_i(m_dat_i), .m_ack_i(m_ack_i),
        .m_err_i(m_err_i), .irq_o(irq_o)
    );

    always #5 wb_clk_i = ~wb_clk_i;

    typedef struct packed {
        logic        we;
        logic [31:0] adr;
        logic [31:0] dat;
    } txn_t;

    txn_t        sb[$];
    txn_t        mon_e;
    logic [31:0] mem [256];
    int          n_checks = 0, n_pass = 0;
    int          txn_cnt = 0, err_txn = -1, stb_cycles = 0;
    logic        ack_on = 1'b1;
    logic [31:0] rd;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp)
            n_pass++;
        else
            $display("FAIL %s: got %h, expected %h", tag, got, exp);
    endtask

    // Memory responder: answers at the negedge so the ack is seen in the strobe cycle.
    always @(negedge wb_clk_i) begin
        m_ack_i = 1'b0;
        m_err_i = 1'b0;
        if (wb_rst_n_i && m_stb_o) begin
            stb_cycles++;
            if (txn_cnt == err_txn) begin
                m_err_i = 1'b1;
                m_ack_i = 1'b1;
                txn_cnt++;
            end else if (ack_on) begin
                m_ack_i = 1'b1;
                txn_cnt++;
                if (sb.size() == 0) begin
                    check("unexpected_beat", m_adr_o, 32'hDEAD_BEEF);
                end else begin
                    mon_e = sb.pop_front();
                    check("beat_we", {31'd0, m_we_o}, {31'd0, mon_e.we});
                    check("beat_adr", m_adr_o, mon_e.adr);
                    if (mon_e.we) begin
                        check("beat_wdata", m_dat_o, mon_e.dat);
                        mem[m_adr_o[9:2]] = m_dat_o;
                    end else begin
                        m_dat_i = mem[m_adr_o[9:2]];
                    end
                end
            end
        end
    end

    task automatic reg_access(input logic we, input logic [1:0] a, input logic [31:0] d,
                              output logic [31:0] q);
        @(negedge wb_clk_i);
        s_cyc_i = 1'b1; s_stb_i = 1'b1; s_we_i = we; s_adr_i = a; s_dat_i = d;
        for (int i = 0; i < 8; i++) begin
            @(posedge wb_clk_i); #1;
            if (s_ack_o) break;
        end
        if (!s_ack_o) check("s_ack_timeout", {31'd0, s_ack_o}, 32'd1);
        q = s_dat_o;
        s_cyc_i = 1'b0; s_stb_i = 1'b0; s_we_i = 1'b0;
    endtask

    task automatic reg_write(input logic [1:0] a, input logic [31:0] d);
        logic [31:0] dummy;
        reg_access(1'b1, a, d, dummy);
    endtask

    task automatic reg_expect(input string tag, input logic [1:0] a, input logic [31:0] exp);
        logic [31:0] q;
        reg_access(1'b0, a, 32'd0, q);
        check(tag, q, exp);
    endtask

    task automatic push_copy(input logic [31:0] s, input logic [31:0] d, input int n);
        for (int i = 0; i < n; i++) begin
            logic [31:0] sa, da;
            sa = s + 32'(4 * i);
            da = d + 32'(4 * i);
            sb.push_back('{1'b0, sa, 32'd0});
            sb.push_back('{1'b1, da, mem[sa[9:2]]});
        end
    endtask

    task automatic wait_irq(input string tag);
        for (int i = 0; i < 200; i++) begin
            @(posedge wb_clk_i); #1;
            if (irq_o) break;
        end
        check(tag, {31'd0, irq_o}, 32'd1);
    endtask

    initial begin
        for (int i = 0; i < 256; i++) mem[i] = $urandom;

        // Reset state
        repeat (3) @(posedge wb_clk_i);
        #1;
        check("rst_outs", {s_ack_o, m_cyc_o, m_stb_o, m_we_o, irq_o, m_sel_o},
              {5'b00000, 4'b1111});
        check("rst_m_adr", m_adr_o, 32'd0);
        check("rst_m_dat", m_dat_o, 32'd0);
        check("rst_s_dat", s_dat_o, 32'd0);
        @(negedge wb_clk_i) wb_rst_n_i = 1'b1;
        for (int a = 0; a < 4; a++) reg_expect("rst_reg", 2'(a), 32'd0);

        // Held request: ack pulses every other cycle, never two in a row
        begin
            int acks;
            int consec;
            acks = 0; consec = 0;
            @(negedge wb_clk_i);
            s_cyc_i = 1'b1; s_stb_i = 1'b1; s_we_i = 1'b0; s_adr_i = 2'd0;
            for (int i = 0; i < 4; i++) begin
                @(posedge wb_clk_i); #1;
                if (s_ack_o) begin acks++; consec++; end else consec = 0;
                if (consec > 1) check("ack_back_to_back", {31'd0, s_ack_o}, 32'd0);
            end
            s_cyc_i = 1'b0; s_stb_i = 1'b0;
            check("ack_count", 32'(acks), 32'd2);
        end

        // Basic copy, LEN=3
        reg_write(2'd0, 32'h100);
        reg_write(2'd1, 32'h200);
        reg_write(2'd2, 32'd3);
        push_copy(32'h100, 32'h200, 3);
        reg_write(2'd3, 32'h5);
        wait_irq("copy_irq");
        check("copy_sb_left", 32'(sb.size()), 32'd0);
        for (int i = 0; i < 3; i++) check("copy_mem", mem[8'h80 + i], mem[8'h40 + i]);
        reg_expect("copy_ctrl", 2'd3, 32'h6);
        reg_expect("copy_src", 2'd0, 32'h10C);
        reg_expect("copy_dst", 2'd1, 32'h20C);
        reg_expect("copy_len", 2'd2, 32'd0);

        // Busy behaviour with a stalled memory: config writes and START ignored, live readback
        ack_on = 1'b0;
        reg_write(2'd1, 32'h240);
        reg_write(2'd2, 32'd2);
        push_copy(32'h10C, 32'h240, 2);
        reg_write(2'd3, 32'h5);
        reg_expect("busy_ctrl", 2'd3, 32'h5);
        reg_write(2'd0, 32'h500);
        reg_write(2'd2, 32'd7);
        reg_write(2'd3, 32'h5);
        reg_expect("busy_src_hold", 2'd0, 32'h10C);
        reg_expect("busy_len_hold", 2'd2, 32'd2);
        ack_on = 1'b1;
        wait_irq("busy_irq");
        reg_expect("busy_dst_end", 2'd1, 32'h248);
        reg_expect("busy_len_end", 2'd2, 32'd0);
        check("busy_sb_left", 32'(sb.size()), 32'd0);

        // LEN=0: no bus activity, DONE one cycle after the START ack
        stb_cycles = 0;
        reg_write(2'd3, 32'h5);
        check("len0_irq_ack_cycle", {31'd0, irq_o}, 32'd0);
        @(posedge wb_clk_i); #1;
        check("len0_irq_next", {31'd0, irq_o}, 32'd1);
        repeat (4) @(posedge wb_clk_i);
        check("len0_no_stb", 32'(stb_cycles), 32'd0);
        reg_expect("len0_ctrl", 2'd3, 32'h6);

        // Bus error (with ack asserted too) on the second read of LEN=4
        reg_write(2'd0, 32'h300);
        reg_write(2'd1, 32'h380);
        reg_write(2'd2, 32'd4);
        push_copy(32'h300, 32'h380, 1);
        txn_cnt = 0; err_txn = 2;
        reg_write(2'd3, 32'h5);
        wait_irq("err_irq");
        err_txn = -1;
        reg_expect("err_ctrl", 2'd3, 32'hE);
        reg_expect("err_len", 2'd2, 32'd3);
        reg_expect("err_src", 2'd0, 32'h304);
        reg_expect("err_dst", 2'd1, 32'h384);
        check("err_sb_left", 32'(sb.size()), 32'd0);
        reg_write(2'd3, 32'hE);
        check("err_w1c_irq", {31'd0, irq_o}, 32'd0);
        reg_expect("err_w1c_ctrl", 2'd3, 32'h4);

        // ABORT during the first beat of LEN=5: exactly one read/write pair
        ack_on = 1'b0;
        reg_write(2'd0, 32'h100);
        reg_write(2'd1, 32'h280);
        reg_write(2'd2, 32'd5);
        push_copy(32'h100, 32'h280, 1);
        txn_cnt = 0;
        reg_write(2'd3, 32'h5);
        reg_write(2'd3, 32'h14);
        ack_on = 1'b1;
        wait_irq("abort_irq");
        repeat (4) @(posedge wb_clk_i);
        check("abort_beats", 32'(txn_cnt), 32'd2);
        reg_expect("abort_ctrl", 2'd3, 32'h6);
        reg_expect("abort_len", 2'd2, 32'd4);

        // ABORT in idle has no effect; address wrap and masked register bits
        reg_write(2'd3, 32'h14);
        reg_write(2'd0, 32'hFFFF_FFFF);
        reg_write(2'd1, 32'h43);
        reg_write(2'd2, 32'hFFFF_0002);
        reg_expect("mask_src", 2'd0, 32'hFFFF_FFFC);
        reg_expect("mask_dst", 2'd1, 32'h40);
        reg_expect("mask_len", 2'd2, 32'd2);
        push_copy(32'hFFFF_FFFC, 32'h40, 2);
        reg_write(2'd3, 32'h5);
        wait_irq("wrap_irq");
        check("wrap_sb_left", 32'(sb.size()), 32'd0);
        reg_expect("wrap_src", 2'd0, 32'h4);
        reg_expect("wrap_ctrl", 2'd3, 32'h6);

`ifdef WB_DMA_TIMEOUT_EN
        // Non-responding slave: strobe held for TIMEOUT cycles, then ERR+TMO
        ack_on = 1'b0;
        reg_write(2'd0, 32'h100);
        reg_write(2'd2, 32'd1);
        stb_cycles = 0;
        reg_write(2'd3, 32'h5);
        wait_irq("tmo_irq");
        check("tmo_stb_cycles", 32'(stb_cycles), 32'd8);
        reg_expect("tmo_ctrl", 2'd3, 32'h2E);
        sb.delete();
        ack_on = 1'b1;
`endif

        // Reset mid-transfer drops the bus immediately
        ack_on = 1'b0;
        reg_write(2'd0, 32'h100);
        reg_write(2'd2, 32'd3);
        reg_write(2'd3, 32'h5);
        for (int i = 0; i < 20; i++) begin
            @(posedge wb_clk_i); #1;
            if (m_stb_o) break;
        end
        check("midrst_stb_before", {31'd0, m_stb_o}, 32'd1);
        @(posedge wb_clk_i); #2;
        wb_rst_n_i = 1'b0;
        #1;
        check("midrst_cyc", {30'd0, m_cyc_o, m_stb_o}, 32'd0);
        @(negedge wb_clk_i) wb_rst_n_i = 1'b1;
        sb.delete();
        ack_on = 1'b1;
        for (int a = 0; a < 4; a++) reg_expect("midrst_reg", 2'(a), 32'd0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
